irq_priority_ctrl: RTL
======================

IRQ_PRIORITY_CTRL -- requirements
Module: irq_priority_ctrl

Interface
REQ-001 Parameter LEVEL, default 0, meaning 0 = pending bit set on request rising edge, 1 = pending bit set while request high.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port Data  input  8  request lines, synchronous to clk; bit 7 highest priority, bit 0 lowest.
REQ-005 Port mask_we  input  1  write strobe for mask register.
REQ-006 Port mask_in  input  8  new mask value; bit=1 disables that source.
REQ-007 Port mask  output  8  current mask register.
REQ-008 Port pending  output  8  current pending register.
REQ-009 Port irq  output  1  registered interrupt request to the service side.
REQ-010 Port Code  output  3  index of the source being requested or serviced.
REQ-011 Port ack  input  1  service side accepts the current irq.
REQ-012 Port eoi  input  1  service side signals end of interrupt.
REQ-013 Port busy  output  1  high while in SERVICE state.

Function
REQ-014 Block SHALL register Data into data_d each cycle; LEVEL=0: set pending[i] when Data[i]=1 and data_d[i]=0; LEVEL=1: set pending[i] when Data[i]=1.
REQ-015 eligible SHALL equal pending & ~mask; winner SHALL be highest set index of eligible (7 beats 0).
REQ-016 FSM states SHALL be IDLE, REQ, SERVICE; irq=1 only in REQ, busy=1 only in SERVICE.
REQ-017 IDLE: eligible!=0 -> REQ next edge, Code loaded with winner on that same edge; eligible==0 -> stay IDLE.
REQ-018 REQ: Code SHALL stay frozen, no preemption by higher-priority arrivals.
REQ-019 REQ with ack=1 -> SERVICE next edge, pending[Code] cleared on that edge.
REQ-020 REQ with mask bit for Code set (current mask, or mask_in when mask_we=1) and no ack -> IDLE next edge, pending retained.
REQ-021 If ack=1 and mask withdrawal coincide, ack SHALL win (go SERVICE).
REQ-022 SERVICE: eoi=1 -> IDLE next edge; no nesting; new pending bits accumulate meanwhile.
REQ-023 ack outside REQ and eoi outside SERVICE SHALL be ignored.
REQ-024 Set and clear of same pending bit in one cycle: set SHALL win (bit stays 1).
REQ-025 mask_we=1 SHALL load mask_in on that edge; mask never affects pending capture.
REQ-026 Latency LEVEL=0: Data rising edge sampled at edge n -> pending at n -> irq at edge n+1 (one cycle after pending visible).
REQ-027 Code SHALL hold its last value in IDLE and SERVICE.

Reset
REQ-028 rst_n low SHALL asynchronously force state IDLE, irq=0, busy=0, Code=3'd0, pending=8'h00, data_d=8'h00, mask=8'hFF.
REQ-029 Reset asserted in REQ or SERVICE SHALL abort the transaction without any further irq until rst_n high and a new request arrives.
REQ-030 After rst_n deasserts, Data lines already high SHALL register as edges on the first edge (data_d=0) when LEVEL=0.

Verification
REQ-031 Reset, mask write 8'h00, Data 8'h00->8'h24 -> pending=8'h24, irq=1 one cycle later, Code=5; ack -> pending=8'h04, busy=1; eoi -> IDLE, then irq=1 Code=2.
REQ-032 In REQ with Code=2, Data bit 7 rises -> Code stays 2 until ack; after eoi next irq has Code=7.
REQ-033 In REQ with Code=5, mask_we with mask_in=8'h20 -> irq=0 next edge, pending[5] still 1; unmask -> irq reasserts Code=5.
REQ-034 LEVEL=0, line 3 rises in the same cycle ack clears pending[3] -> pending[3] remains 1, second irq Code=3 after eoi.
REQ-035 Reset pulse mid-SERVICE -> busy=0, irq=0, pending=8'h00, mask=8'hFF immediately, before next clock edge.
REQ-036 Default mask 8'hFF, Data=8'hFF -> pending=8'hFF, irq never asserts; ack/eoi pulses in IDLE cause no state change.

Source files
------------

// File: rtl/irq_priority_ctrl.sv
// Eight-source priority interrupt controller.
// Requests are captured into a pending register (edge or level sensitive),
// filtered by a mask register, and the highest-index eligible source is
// presented to the service side through a REQ -> SERVICE handshake.
module irq_priority_ctrl #(
    parameter int LEVEL = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] Data,
    input  logic       mask_we,
    input  logic [7:0] mask_in,
    output logic [7:0] mask,
    output logic [7:0] pending,
    output logic       irq,
    output logic [2:0] Code,
    input  logic       ack,
    input  logic       eoi,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] data_d_reg;
    logic [7:0] pending_reg, pending_next;
    logic [7:0] mask_reg;
    logic [2:0] code_reg, code_next;
    logic       irq_reg, busy_reg;

    logic [7:0] set_vec;
    logic [7:0] clr_vec;
    logic [7:0] eligible;
    logic [7:0] mask_eff;
    logic [2:0] winner;

    // A mask write in the same cycle already withdraws the request in REQ.
    assign mask_eff = mask_we ? mask_in : mask_reg;
    assign eligible = pending_reg & ~mask_reg;

    // Per-bit capture and update; a new set always beats a same-cycle clear.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bit
            if (LEVEL != 0) begin : g_level
                assign set_vec[gi] = Data[gi];
            end else begin : g_edge
                assign set_vec[gi] = Data[gi] & ~data_d_reg[gi];
            end
            assign pending_next[gi] = set_vec[gi] | (pending_reg[gi] & ~clr_vec[gi]);
        end
    endgenerate

    // Priority encoder: ascending scan so the highest set index wins.
    always_comb begin
        winner = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (eligible[i]) begin
                winner = 3'(i);
            end
        end
    end

    // Next-state logic for the request/service handshake.
    always_comb begin
        state_next = state_reg;
        code_next  = code_reg;
        clr_vec    = 8'h00;
        case (state_reg)
            S_IDLE: begin
                if (|eligible) begin
                    state_next = S_REQ;
                    code_next  = winner;
                end
            end
            S_REQ: begin
                // Code is frozen here: later, higher-priority arrivals wait.
                if (ack) begin
                    state_next = S_SERVICE;
                    clr_vec    = 8'd1 << code_reg;
                end else if (mask_eff[code_reg]) begin
                    state_next = S_IDLE;
                end
            end
            S_SERVICE: begin
                if (eoi) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State, capture and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            code_reg    <= 3'd0;
            pending_reg <= 8'h00;
            data_d_reg  <= 8'h00;
            mask_reg    <= 8'hFF;
            irq_reg     <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            code_reg    <= code_next;
            pending_reg <= pending_next;
            data_d_reg  <= Data;
            if (mask_we) begin
                mask_reg <= mask_in;
            end
            irq_reg     <= (state_next == S_REQ);
            busy_reg    <= (state_next == S_SERVICE);
        end
    end

    assign mask    = mask_reg;
    assign pending = pending_reg;
    assign irq     = irq_reg;
    assign busy    = busy_reg;
    assign Code    = code_reg;

endmodule
